fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32: data/address width; only 32 is supported.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value after reset; bits [1:0] are 0.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fetch_req  input  1  controller requests the next instruction; sampled only in IDLE.
REQ-006 redirect_valid  input  1  jump/branch taken; load PC from redirect_pc.
REQ-007 redirect_pc  input  WIDTH  jump/branch target address.
REQ-008 imem_req  output  1  instruction-memory read request, held until imem_ack.
REQ-009 imem_addr  output  WIDTH  read address; equals pc and is stable while imem_req=1.
REQ-010 imem_ack  input  1  memory response; imem_rdata is valid in the same cycle.
REQ-011 imem_rdata  input  WIDTH  instruction word.
REQ-012 ir  output  WIDTH  instruction register.
REQ-013 opcode  output  rv32i_opcode_t  ir[6:0], combinational, feeds the controller.
REQ-014 inst_valid  output  1  ir holds a fresh, unsquashed instruction.
REQ-015 pc  output  WIDTH  address of the next fetch.
REQ-016 inst_pc  output  WIDTH  address of the instruction currently in ir.
REQ-017 fetch_count  output  WIDTH  number of instructions captured into ir.
REQ-018 misalign_fault  output  1  sticky flag: a redirect target was not word-aligned.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT, SQUASH and FAULT.
REQ-020 IDLE, fetch_req=1, redirect_valid=0: go to WAIT next cycle and clear inst_valid.
REQ-021 WAIT drives imem_req=1 and imem_addr=pc; imem_req is low in every other state.
REQ-022 WAIT, imem_ack=1, at the edge:
  - ir <= imem_rdata;
  - inst_pc <= pc;
  - pc <= pc+4, modulo 2^32;
  - inst_valid <= 1;
  - fetch_count <= fetch_count+1, wrapping;
  - state <= IDLE.
REQ-023 Minimum latency: fetch_req in cycle N, ack in cycle N+1, ir and inst_valid visible in cycle N+2.
REQ-024 WAIT, imem_ack=0: hold state; imem_addr is unchanged.
REQ-025 fetch_req is ignored in WAIT, SQUASH and FAULT.
REQ-026 IDLE, redirect_valid=1, redirect_pc[1:0]=0: pc <= redirect_pc; inst_valid <= 0; a simultaneous fetch_req is dropped (the controller reissues it).
REQ-027 WAIT, redirect_valid=1, imem_ack=0: latch redirect_pc into a pending register and go to SQUASH; imem_req stays 1 with the old address.
REQ-028 SQUASH, on imem_ack:
  - discard the data: ir, inst_pc and fetch_count are unchanged, inst_valid=0;
  - pc <= pending target;
  - go to IDLE.
REQ-029 WAIT, redirect_valid=1 and imem_ack=1 in the same cycle: discard the data; pc <= redirect_pc; go to IDLE.
REQ-030 SQUASH, a further redirect_valid: the pending target is overwritten (last redirect wins).
REQ-031 Any redirect with redirect_pc[1:0]≠0:
  - set misalign_fault;
  - go to FAULT;
  - pc is unchanged;
  - an in-flight request is abandoned: imem_req drops and any later ack is ignored.
REQ-032 FAULT is terminal until rst: imem_req=0, inst_valid=0.

Reset
REQ-033 On rst, immediately and asynchronously:
  - state=IDLE, pc=RESET_PC, inst_pc=RESET_PC;
  - ir=0, inst_valid=0, fetch_count=0, misalign_fault=0;
  - imem_req=0, pending target=0.
REQ-034 rst asserted in WAIT or SQUASH abandons the request; a later ack in IDLE is ignored.

Structure
REQ-035 rv32i_opcode_t comes from the shared rv32i_opcodes package; add INST_BYTES=4 to that package.
REQ-036 The FSM state enum is local to the module; no sub-module (a single module is sufficient).

Verification
REQ-037 Reset, then fetch_req with ack 1 cycle later, rdata=32'h00500093 → ir=32'h00500093, opcode=OP_IMM, inst_pc=0, pc=4, fetch_count=1.
REQ-038 Ack delayed 5 cycles → imem_req high for exactly 5 cycles with imem_addr constant; capture in the 6th cycle.
REQ-039 In IDLE, redirect to 32'h100 together with fetch_req → pc=32'h100 and no request; the next fetch_req gives imem_addr=32'h100.
REQ-040 Redirect to 32'h200 in WAIT, ack 3 cycles later → ir unchanged, inst_valid=0, pc=32'h200, fetch_count unchanged.
REQ-041 Redirect to 32'h102 → misalign_fault=1, imem_req=0, later fetch_req ignored until rst.
REQ-042 Redirect to 32'hFFFF_FFFC and fetch → pc wraps to 0 after capture; rst asserted mid-WAIT → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/rv32i_opcodes.sv
// Shared RV32I definitions: base opcode encodings and instruction size.
package rv32i_opcodes;

  localparam int INST_BYTES = 4;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } rv32i_opcode_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel: request held until ack, data valid with ack.
interface fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one word per fetch_req, redirects squash in-flight reads,
// misaligned redirect targets lock the unit in FAULT until reset.
module fetch_unit
  import rv32i_opcodes::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_req,
  input  logic                 redirect_valid,
  input  logic [WIDTH-1:0]     redirect_pc,
  fetch_unit_if.master         imem,
  output logic [WIDTH-1:0]     ir,
  output rv32i_opcode_t        opcode,
  output logic                 inst_valid,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     inst_pc,
  output logic [WIDTH-1:0]     fetch_count,
  output logic                 misalign_fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SQUASH = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pending_pc;
  logic             imem_req_q;
  logic             redir_ok;
  logic             redir_bad;

  assign redir_ok       = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad      = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign imem.imem_req  = imem_req_q;
  // pc only moves when the request completes, so the address is stable while pending
  assign imem.imem_addr = pc;
  assign opcode         = rv32i_opcode_t'(ir[6:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      inst_pc        <= RESET_PC;
      ir             <= '0;
      inst_valid     <= 1'b0;
      fetch_count    <= '0;
      misalign_fault <= 1'b0;
      imem_req_q     <= 1'b0;
      pending_pc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redir_bad) begin
            misalign_fault <= 1'b1;
            inst_valid     <= 1'b0;
            state          <= FAULT;
          end else if (redir_ok) begin
            pc         <= redirect_pc;
            inst_valid <= 1'b0;
          end else if (fetch_req) begin
            inst_valid <= 1'b0;
            imem_req_q <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (redir_bad) begin
            misalign_fault <= 1'b1;
            inst_valid     <= 1'b0;
            imem_req_q     <= 1'b0;
            state          <= FAULT;
          end else if (redir_ok && imem.imem_ack) begin
            pc         <= redirect_pc;
            imem_req_q <= 1'b0;
            state      <= IDLE;
          end else if (redir_ok) begin
            pending_pc <= redirect_pc;
            state      <= SQUASH;
          end else if (imem.imem_ack) begin
            ir          <= imem.imem_rdata;
            inst_pc     <= pc;
            pc          <= pc + WIDTH'(INST_BYTES);
            inst_valid  <= 1'b1;
            fetch_count <= fetch_count + 1'b1;
            imem_req_q  <= 1'b0;
            state       <= IDLE;
          end
        end
        SQUASH: begin
          if (redir_bad) begin
            misalign_fault <= 1'b1;
            imem_req_q     <= 1'b0;
            state          <= FAULT;
          end else if (imem.imem_ack) begin
            // a redirect arriving with the ack is newer than the pending target
            pc         <= redir_ok ? redirect_pc : pending_pc;
            imem_req_q <= 1'b0;
            state      <= IDLE;
          end else if (redir_ok) begin
            pending_pc <= redirect_pc;
          end
        end
        default: begin
          imem_req_q <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-computed expectations checked with immediate assertions.
module tb_fetch_unit;
  import rv32i_opcodes::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] ir, pc, inst_pc, fetch_count;
  rv32i_opcode_t opcode;
  logic        inst_valid, misalign_fault;
  int          total = 0;
  int          bad = 0;
  int          req_cycles;

  fetch_unit_if #(.WIDTH(32)) imem ();

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(imem.master), .ir(ir), .opcode(opcode), .inst_valid(inst_valid),
    .pc(pc), .inst_pc(inst_pc), .fetch_count(fetch_count),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_inst_pc"}, inst_pc, 32'h0);
    check({tag, "_ir"}, ir, 32'h0);
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
    check({tag, "_count"}, fetch_count, 32'h0);
    check({tag, "_fault"}, {31'b0, misalign_fault}, 32'h0);
    check({tag, "_req"}, {31'b0, imem.imem_req}, 32'h0);
  endtask

  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;

    // reset
    #2 rst = 1'b1;
    #1 check_reset_values("rst");
    tick(); tick();
    #2 rst = 1'b0;
    tick();

    // minimum-latency fetch
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("f1_req", {31'b0, imem.imem_req}, 32'h1);
    check("f1_addr", imem.imem_addr, 32'h0);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h00500093;
    tick();
    imem.imem_ack = 1'b0;
    check("f1_ir", ir, 32'h00500093);
    check("f1_opcode", {25'b0, opcode}, {25'b0, OP_IMM});
    check("f1_inst_pc", inst_pc, 32'h0);
    check("f1_pc", pc, 32'h4);
    check("f1_count", fetch_count, 32'h1);
    check("f1_valid", {31'b0, inst_valid}, 32'h1);
    check("f1_req_done", {31'b0, imem.imem_req}, 32'h0);

    // ack on the fifth cycle of the request
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem.imem_req) begin
        req_cycles++;
        check("f2_addr", imem.imem_addr, 32'h4);
      end
      if (req_cycles == 5 && imem.imem_req) begin
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'h000002B7;
      end
      tick();
      imem.imem_ack = 1'b0;
    end
    check("f2_req_cycles", req_cycles, 5);
    check("f2_ir", ir, 32'h000002B7);
    check("f2_opcode", {25'b0, opcode}, {25'b0, OP_LUI});
    check("f2_inst_pc", inst_pc, 32'h4);
    check("f2_pc", pc, 32'h8);
    check("f2_count", fetch_count, 32'h2);

    // redirect in IDLE wins over a simultaneous fetch_req
    redirect_valid = 1'b1; redirect_pc = 32'h100; fetch_req = 1'b1;
    tick();
    redirect_valid = 1'b0; fetch_req = 1'b0;
    check("r1_pc", pc, 32'h100);
    check("r1_req", {31'b0, imem.imem_req}, 32'h0);
    check("r1_valid", {31'b0, inst_valid}, 32'h0);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("r1_addr", imem.imem_addr, 32'h100);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h0000006F;
    tick();
    imem.imem_ack = 1'b0;
    check("r1_ir", ir, 32'h0000006F);
    check("r1_opcode", {25'b0, opcode}, {25'b0, OP_JAL});
    check("r1_count", fetch_count, 32'h3);

    // redirect while waiting: squash, ack three cycles later
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("sq_req", {31'b0, imem.imem_req}, 32'h1);
    check("sq_addr", imem.imem_addr, 32'h104);
    tick();
    tick();
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEADBEEF;
    tick();
    imem.imem_ack = 1'b0;
    check("sq_ir", ir, 32'h0000006F);
    check("sq_valid", {31'b0, inst_valid}, 32'h0);
    check("sq_pc", pc, 32'h200);
    check("sq_count", fetch_count, 32'h3);
    check("sq_inst_pc", inst_pc, 32'h100);
    check("sq_req_done", {31'b0, imem.imem_req}, 32'h0);

    // redirect and ack in the same cycle
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h12345678;
    tick();
    redirect_valid = 1'b0; imem.imem_ack = 1'b0;
    check("rs_pc", pc, 32'h300);
    check("rs_ir", ir, 32'h0000006F);
    check("rs_count", fetch_count, 32'h3);
    check("rs_req", {31'b0, imem.imem_req}, 32'h0);

    // last redirect wins during squash
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_pc = 32'h500;
    tick();
    redirect_valid = 1'b0;
    imem.imem_ack = 1'b1;
    tick();
    imem.imem_ack = 1'b0;
    check("lw_pc", pc, 32'h500);
    check("lw_count", fetch_count, 32'h3);

    // pc wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("wr_addr", imem.imem_addr, 32'hFFFF_FFFC);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h00000033;
    tick();
    imem.imem_ack = 1'b0;
    check("wr_pc", pc, 32'h0);
    check("wr_inst_pc", inst_pc, 32'hFFFF_FFFC);
    check("wr_opcode", {25'b0, opcode}, {25'b0, OP_REG});
    check("wr_count", fetch_count, 32'h4);

    // asynchronous reset mid-request, stale ack afterwards
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("ar_req_before", {31'b0, imem.imem_req}, 32'h1);
    #2 rst = 1'b1;
    #1 check_reset_values("ar");
    #1 rst = 1'b0;
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hCAFEF00D;
    tick();
    imem.imem_ack = 1'b0;
    check("ar_ir_after", ir, 32'h0);
    check("ar_count_after", fetch_count, 32'h0);
    check("ar_valid_after", {31'b0, inst_valid}, 32'h0);

    // misaligned redirect during a request
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    check("mf_fault", {31'b0, misalign_fault}, 32'h1);
    check("mf_req", {31'b0, imem.imem_req}, 32'h0);
    check("mf_pc", pc, 32'h0);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h00500093;
    tick();
    imem.imem_ack = 1'b0;
    check("mf_ir", ir, 32'h0);
    check("mf_count", fetch_count, 32'h0);
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mf_locked_req", {31'b0, imem.imem_req}, 32'h0);
      check("mf_locked_valid", {31'b0, inst_valid}, 32'h0);
    end
    fetch_req = 1'b0;
    #2 rst = 1'b1;
    #1 check("mf_cleared", {31'b0, misalign_fault}, 32'h0);
    #1 rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
